// File: rtl/vc_to_d_router.sv
// Pops VC0/VC1 words with strict VC0 priority and steers each into D0 or D1 by its destination bit.
// Downstream full/almost-full flags throttle popping so that the D FIFOs never overflow.
module vc_to_d_router #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic                  vc0_empty,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  vc1_empty,
    input  logic                  d0_full,
    input  logic                  d0_almost_full,
    input  logic                  d1_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic [CNT_WIDTH-1:0]  d0_count,
    output logic [CNT_WIDTH-1:0]  d1_count,
    output logic                  idle
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  stall;
    logic                  any_data;
    logic                  valid_q;
    logic                  src_q;
    logic [DATA_WIDTH-1:0] word;

    // Almost-full also stalls so that the one word already in flight still has a free slot.
    assign stall    = d0_full | d0_almost_full | d1_full | d1_almost_full;
    assign any_data = !vc0_empty || !vc1_empty;

    assign vc0_pop = !stall && !vc0_empty;
    assign vc1_pop = !stall && vc0_empty && !vc1_empty;

    assign word = src_q ? vc1_data : vc0_data;
    assign idle = (state == ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_data) state_next = stall ? ST_STALL : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (stall)          state_next = ST_STALL;
                else if (!any_data) state_next = ST_IDLE;
            end
            ST_STALL: begin
                if (!stall) state_next = any_data ? ST_ACTIVE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_next;
    end

    // The FIFO returns the popped word one cycle later, so remember which VC it came from.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            src_q   <= 1'b0;
            d_data  <= '0;
            d0_push <= 1'b0;
            d1_push <= 1'b0;
        end else begin
            valid_q <= vc0_pop | vc1_pop;
            src_q   <= vc1_pop;
            d_data  <= valid_q ? word : '0;
            d0_push <= valid_q & ~word[DEST_BIT];
            d1_push <= valid_q & word[DEST_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d0_count <= '0;
            d1_count <= '0;
        end else begin
            if (d0_push) d0_count <= d0_count + CNT_ONE;
            if (d1_push) d1_count <= d1_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_vc_to_d_router.sv
// Directed bench for vc_to_d_router: behavioural VC FIFOs and a size-4 D0 occupancy model
// drive the router, with hand-computed expectations checked after each step.
module tb_vc_to_d_router;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          vc0_empty, vc1_empty;
    logic          d0_full, d0_almost_full, d1_full, d1_almost_full;
    logic          vc0_pop, vc1_pop, d0_push, d1_push, idle;
    logic [DW-1:0] d_data;
    logic [CW-1:0] d0_count, d1_count;

    int            compared = 0;
    int            mismatched = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            d0_occ;
    bit            d0_drain;
    logic [DW-1:0] stream [8];

    always #5 clk = ~clk;

    vc_to_d_router #(.DATA_WIDTH(DW), .DEST_BIT(4), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .vc0_data       (vc0_data),
        .vc0_empty      (vc0_empty),
        .vc1_data       (vc1_data),
        .vc1_empty      (vc1_empty),
        .d0_full        (d0_full),
        .d0_almost_full (d0_almost_full),
        .d1_full        (d1_full),
        .d1_almost_full (d1_almost_full),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .d_data         (d_data),
        .d0_count       (d0_count),
        .d1_count       (d1_count),
        .idle           (idle)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: VC FIFOs answer pops one cycle later, D0 fills on push and drains when enabled.
    task automatic applyStimulus();
        logic p0, p1, dp0;
        #1;
        p0  = vc0_pop;
        p1  = vc1_pop;
        dp0 = d0_push;
        checkOutput("d0_push_while_full", 32'(d0_push & d0_full), 32'h0);
        checkOutput("d1_push_while_full", 32'(d1_push & d1_full), 32'h0);
        @(posedge clk);
        #1;
        vc0_data  = (p0 && q0.size() > 0) ? q0.pop_front() : '0;
        vc1_data  = (p1 && q1.size() > 0) ? q1.pop_front() : '0;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        d0_occ    = d0_occ + (dp0 ? 1 : 0) - ((d0_drain && d0_occ > 0) ? 1 : 0);
        d0_full        = (d0_occ >= 4);
        d0_almost_full = (d0_occ == 3);
        #1;
    endtask

    initial begin
        reset_L = 1'b0;
        vc0_data = '0; vc1_data = '0;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        d0_full = 1'b0; d0_almost_full = 1'b0; d1_full = 1'b0; d1_almost_full = 1'b0;
        d0_occ = 0; d0_drain = 1'b1;
        stream = '{6'h00, 6'h10, 6'h01, 6'h11, 6'h02, 6'h12, 6'h03, 6'h13};

        // Reset state
        repeat (2) applyStimulus();
        checkOutput("rst_d0_push", 32'(d0_push), 32'h0);
        checkOutput("rst_d1_push", 32'(d1_push), 32'h0);
        checkOutput("rst_d_data", 32'(d_data), 32'h0);
        checkOutput("rst_d0_count", 32'(d0_count), 32'h0);
        checkOutput("rst_d1_count", 32'(d1_count), 32'h0);
        checkOutput("rst_idle", 32'(idle), 32'h1);
        reset_L = 1'b1;
        applyStimulus();

        // Single VC0 word to D0, two-cycle latency
        q0.push_back(6'h05); vc0_empty = 1'b0; #1;
        checkOutput("t1_vc0_pop", 32'(vc0_pop), 32'h1);
        applyStimulus();
        checkOutput("t1_pop_done", 32'(vc0_pop), 32'h0);
        checkOutput("t1_active", 32'(idle), 32'h0);
        checkOutput("t1_no_early_push", 32'(d0_push), 32'h0);
        applyStimulus();
        checkOutput("t1_d0_push", 32'(d0_push), 32'h1);
        checkOutput("t1_d1_push", 32'(d1_push), 32'h0);
        checkOutput("t1_d_data", 32'(d_data), 32'h05);
        applyStimulus();
        checkOutput("t1_d0_count", 32'(d0_count), 32'h1);
        checkOutput("t1_push_clear", 32'(d0_push), 32'h0);
        checkOutput("t1_idle", 32'(idle), 32'h1);

        // VC0 priority over VC1
        q0.push_back(6'h15); q1.push_back(6'h02);
        vc0_empty = 1'b0; vc1_empty = 1'b0; #1;
        checkOutput("t2_vc0_first", 32'(vc0_pop), 32'h1);
        checkOutput("t2_vc1_held", 32'(vc1_pop), 32'h0);
        applyStimulus();
        checkOutput("t2_vc1_pop", 32'(vc1_pop), 32'h1);
        checkOutput("t2_vc0_none", 32'(vc0_pop), 32'h0);
        applyStimulus();
        checkOutput("t2_d1_push", 32'(d1_push), 32'h1);
        checkOutput("t2_d0_quiet", 32'(d0_push), 32'h0);
        checkOutput("t2_d_data_a", 32'(d_data), 32'h15);
        applyStimulus();
        checkOutput("t2_d0_push", 32'(d0_push), 32'h1);
        checkOutput("t2_d_data_b", 32'(d_data), 32'h02);
        applyStimulus();
        checkOutput("t2_d0_count", 32'(d0_count), 32'h2);
        checkOutput("t2_d1_count", 32'(d1_count), 32'h1);

        // D0 fills to full without overflow, pops resume after it drains
        repeat (2) applyStimulus();
        d0_drain = 1'b0;
        q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03); q0.push_back(6'h04);
        vc0_empty = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("t3_push3", 32'(d_data), 32'h03);
        applyStimulus();
        checkOutput("t3_push4", 32'(d_data), 32'h04);
        checkOutput("t3_push4_en", 32'(d0_push), 32'h1);
        applyStimulus();
        checkOutput("t3_full_no_push", 32'(d0_push), 32'h0);
        q0.push_back(6'h06); vc0_empty = 1'b0; #1;
        checkOutput("t3_full_no_pop", 32'(vc0_pop), 32'h0);
        applyStimulus();
        checkOutput("t3_stall_state", 32'(idle), 32'h0);
        checkOutput("t3_stall_no_pop", 32'(vc0_pop), 32'h0);
        d0_drain = 1'b1;
        applyStimulus();
        checkOutput("t3_almost_no_pop", 32'(vc0_pop), 32'h0);
        applyStimulus();
        checkOutput("t3_resume_pop", 32'(vc0_pop), 32'h1);
        repeat (2) applyStimulus();
        checkOutput("t3_resume_push", 32'(d0_push), 32'h1);
        checkOutput("t3_resume_data", 32'(d_data), 32'h06);
        applyStimulus();
        checkOutput("t3_d0_count", 32'(d0_count), 32'h7);

        // Continuous stream, alternating destination, one push per cycle
        for (int i = 0; i < 8; i++) q0.push_back(stream[i]);
        vc0_empty = 1'b0;
        applyStimulus();
        checkOutput("t4_active", 32'(idle), 32'h0);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] w;
            w = stream[i];
            applyStimulus();
            checkOutput("t4_d_data", 32'(d_data), 32'(w));
            checkOutput("t4_d0_push", 32'(d0_push), 32'(!w[4]));
            checkOutput("t4_d1_push", 32'(d1_push), 32'(w[4]));
            checkOutput("t4_idle", 32'(idle), 32'(i == 7));
        end
        applyStimulus();
        checkOutput("t4_d0_count", 32'(d0_count), 32'd11);
        checkOutput("t4_d1_count", 32'(d1_count), 32'd5);

        // Almost-full arriving with a word in flight
        q0.push_back(6'h15); q0.push_back(6'h05); vc0_empty = 1'b0; #1;
        checkOutput("t5_pop", 32'(vc0_pop), 32'h1);
        applyStimulus();
        d1_almost_full = 1'b1; #1;
        checkOutput("t5_stall_no_pop", 32'(vc0_pop), 32'h0);
        applyStimulus();
        checkOutput("t5_inflight_push", 32'(d1_push), 32'h1);
        checkOutput("t5_inflight_data", 32'(d_data), 32'h15);
        checkOutput("t5_still_no_pop", 32'(vc0_pop), 32'h0);
        checkOutput("t5_stall_state", 32'(idle), 32'h0);
        applyStimulus();
        checkOutput("t5_no_push", 32'(d1_push), 32'h0);
        checkOutput("t5_data_zero", 32'(d_data), 32'h0);
        d1_almost_full = 1'b0; #1;
        checkOutput("t5_resume_pop", 32'(vc0_pop), 32'h1);
        repeat (2) applyStimulus();
        checkOutput("t5_d0_push", 32'(d0_push), 32'h1);
        checkOutput("t5_d_data", 32'(d_data), 32'h05);
        applyStimulus();
        checkOutput("t5_d0_count", 32'(d0_count), 32'd12);
        checkOutput("t5_d1_count", 32'(d1_count), 32'd6);

        // Asynchronous reset mid-stream
        q0.push_back(6'h11); q0.push_back(6'h02); q0.push_back(6'h03); vc0_empty = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("t6_pre_push", 32'(d1_push), 32'h1);
        #2;
        reset_L = 1'b0;
        q0.delete(); vc0_data = '0; vc0_empty = 1'b1; d0_occ = 0;
        d0_full = 1'b0; d0_almost_full = 1'b0;
        #1;
        checkOutput("t6_rst_d1_push", 32'(d1_push), 32'h0);
        checkOutput("t6_rst_d_data", 32'(d_data), 32'h0);
        checkOutput("t6_rst_d0_count", 32'(d0_count), 32'h0);
        checkOutput("t6_rst_d1_count", 32'(d1_count), 32'h0);
        checkOutput("t6_rst_idle", 32'(idle), 32'h1);
        repeat (2) applyStimulus();
        reset_L = 1'b1;
        q0.push_back(6'h1A); vc0_empty = 1'b0; #1;
        checkOutput("t6_post_pop", 32'(vc0_pop), 32'h1);
        repeat (2) applyStimulus();
        checkOutput("t6_post_d1_push", 32'(d1_push), 32'h1);
        checkOutput("t6_post_d0_push", 32'(d0_push), 32'h0);
        checkOutput("t6_post_data", 32'(d_data), 32'h1A);
        applyStimulus();
        checkOutput("t6_post_d1_count", 32'(d1_count), 32'h1);
        checkOutput("t6_post_d0_count", 32'(d0_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
